// File: rtl/buf_tag_mgr_pkg.sv
`default_nettype none
// ============================================================================
// buf_tag_mgr_pkg : shared types and constants for the 4-buffer tag manager
// Revision : 1.0
// ============================================================================
package buf_tag_mgr_pkg;

    localparam int NUM_BUF = 4;

    typedef logic [1:0] buf_idx_t;

    typedef buf_idx_t [NUM_BUF-1:0] lru_vec_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_FILL   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Element 0 is the oldest position, element NUM_BUF-1 the newest.
    localparam lru_vec_t LRU_RESET_ORDER = {2'd3, 2'd2, 2'd1, 2'd0};

    function automatic buf_idx_t first_invalid(input logic [NUM_BUF-1:0] valid);
        buf_idx_t idx;
        idx = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (!valid[i]) idx = buf_idx_t'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/buf_tag_mgr_if.sv
`default_nettype none
// ============================================================================
// buf_tag_mgr_if : request / response / fill handshake bundle
// Revision : 1.0
// ============================================================================
interface buf_tag_mgr_if
    import buf_tag_mgr_pkg::*;
#(
    parameter int TAG_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    buf_idx_t         rsp_buf;
    logic             fill_req;
    buf_idx_t         fill_buf;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_done;

    modport master (
        output req_valid, req_tag, rsp_ready, fill_done,
        input  req_ready, rsp_valid, rsp_hit, rsp_buf, fill_req, fill_buf, fill_tag
    );

    modport slave (
        input  req_valid, req_tag, rsp_ready, fill_done,
        output req_ready, rsp_valid, rsp_hit, rsp_buf, fill_req, fill_buf, fill_tag
    );
endinterface
`default_nettype wire

// File: rtl/buf_tag_mgr_lru_order4.sv
`default_nettype none
// ============================================================================
// lru_order4 : 4-entry recency permutation with move-to-MRU touch
// Revision : 1.0
// ============================================================================
module lru_order4
    import buf_tag_mgr_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     touch_en,
    input  wire buf_idx_t touch_buf,
    output buf_idx_t      lru_buf
);
    lru_vec_t r_order;
    lru_vec_t w_next;
    logic     w_seen;

    // Entries from the touched slot upward slide one step older; the touched
    // buffer lands in the newest slot.
    always_comb begin
        w_next = r_order;
        w_seen = 1'b0;
        if (touch_en) begin
            for (int i = 0; i < NUM_BUF - 1; i++) begin
                if (r_order[i] == touch_buf) w_seen = 1'b1;
                if (w_seen) w_next[i] = r_order[i+1];
            end
            w_next[NUM_BUF-1] = touch_buf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_order <= LRU_RESET_ORDER;
        end else begin
            r_order <= w_next;
        end
    end

    assign lru_buf = r_order[0];

endmodule
`default_nettype wire

// File: rtl/buf_tag_mgr.sv
`default_nettype none
// ============================================================================
// buf_tag_mgr : 4-buffer tag lookup with LRU fill; optional BUF_TAG_MGR_STATS_EN
// Revision : 1.0
// ============================================================================
module buf_tag_mgr
    import buf_tag_mgr_pkg::*;
#(
    parameter int TAG_W = 8
)(
    input  wire logic    clk,
    input  wire logic    rst_n,
    buf_tag_mgr_if.slave bus
`ifdef BUF_TAG_MGR_STATS_EN
    ,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
`endif
);
    state_t             r_state;
    logic [TAG_W-1:0]   r_tag;
    logic [TAG_W-1:0]   r_tags [NUM_BUF];
    logic [NUM_BUF-1:0] r_valid;

    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_rsp_hit;
    buf_idx_t           r_rsp_buf;
    logic               r_fill_req;
    buf_idx_t           r_fill_buf;
    logic [TAG_W-1:0]   r_fill_tag;

    logic               w_hit;
    buf_idx_t           w_hit_buf;
    buf_idx_t           w_lru_buf;
    buf_idx_t           w_victim;
    logic               w_touch_en;
    buf_idx_t           w_touch_buf;

    // Descending scan so the lowest matching index wins if tags ever alias.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_buf = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tags[i] == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_buf = buf_idx_t'(i);
            end
        end
    end

    assign w_victim    = (&r_valid) ? w_lru_buf : first_invalid(r_valid);
    assign w_touch_en  = ((r_state == S_LOOKUP) && w_hit) ||
                         ((r_state == S_FILL) && bus.fill_done);
    assign w_touch_buf = (r_state == S_LOOKUP) ? w_hit_buf : r_fill_buf;

    lru_order4 u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .touch_en  (w_touch_en),
        .touch_buf (w_touch_buf),
        .lru_buf   (w_lru_buf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tag       <= '0;
            r_valid     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_buf   <= '0;
            r_fill_req  <= 1'b0;
            r_fill_buf  <= '0;
            r_fill_tag  <= '0;
            for (int i = 0; i < NUM_BUF; i++) r_tags[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_tag       <= bus.req_tag;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_rsp_hit   <= 1'b1;
                        r_rsp_buf   <= w_hit_buf;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_fill_buf  <= w_victim;
                        r_fill_tag  <= r_tag;
                        r_fill_req  <= 1'b1;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.fill_done) begin
                        r_tags[r_fill_buf]  <= r_fill_tag;
                        r_valid[r_fill_buf] <= 1'b1;
                        r_fill_req          <= 1'b0;
                        r_rsp_hit           <= 1'b0;
                        r_rsp_buf           <= r_fill_buf;
                        r_rsp_valid         <= 1'b1;
                        r_state             <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_hit   = r_rsp_hit;
    assign bus.rsp_buf   = r_rsp_buf;
    assign bus.fill_req  = r_fill_req;
    assign bus.fill_buf  = r_fill_buf;
    assign bus.fill_tag  = r_fill_tag;

`ifdef BUF_TAG_MGR_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if ((r_state == S_RESP) && bus.rsp_ready) begin
            if (r_rsp_hit) begin
                if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/buf_tag_mgr.md
BUF_TAG_MGR -- requirements
Module: buf_tag_mgr

Interface
REQ-001 SHALL have parameter TAG_W, default 8, giving the tag width in bits.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, lookup request present.
REQ-005 SHALL have port req_ready, output, 1, block accepts a request.
REQ-006 SHALL have port req_tag, input, TAG_W, tag to look up.
REQ-007 SHALL have port rsp_valid, output, 1, response present.
REQ-008 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-009 SHALL have port rsp_hit, output, 1, 1 = tag was resident, 0 = tag was filled.
REQ-010 SHALL have port rsp_buf, output, 2, buffer number holding the tag.
REQ-011 SHALL have port fill_req, output, 1, request to load a buffer.
REQ-012 SHALL have port fill_buf, output, 2, buffer to load.
REQ-013 SHALL have port fill_tag, output, TAG_W, tag to load.
REQ-014 SHALL have port fill_done, input, 1, single-cycle pulse when the fill completes.

Function
REQ-015 SHALL manage 4 buffers, each holding one valid bit and one TAG_W tag.
REQ-016 SHALL implement the states IDLE, LOOKUP, FILL, RESP.
REQ-017 IDLE: req_ready=1; on req_valid, SHALL capture req_tag and move to LOOKUP.
REQ-018 req_ready SHALL be 0 in every state other than IDLE.
REQ-019 LOOKUP (one cycle): SHALL compare the captured tag against all valid entries.
REQ-020 On a hit in LOOKUP:
- rsp_buf = matching buffer, rsp_hit=1;
- the matching buffer SHALL be marked most-recently-used;
- next state is RESP.
REQ-021 On a miss in LOOKUP:
- victim = lowest-index invalid buffer if any exists, else the least-recently-used buffer;
- fill_buf = victim, fill_tag = captured tag;
- next state is FILL.
REQ-022 FILL: fill_req SHALL be held at 1 and fill_buf/fill_tag held stable until fill_done is sampled high.
REQ-023 On fill_done:
- the victim's tag is written and its valid bit set to 1;
- the victim is marked MRU;
- rsp_hit=0, rsp_buf = victim;
- next state is RESP.
REQ-024 fill_done SHALL be ignored outside FILL.
REQ-025 RESP: rsp_valid=1 with rsp_hit/rsp_buf stable; SHALL return to IDLE in the cycle rsp_ready is sampled high.
REQ-026 Latency SHALL be:
- hit: request accept to rsp_valid = 2 cycles;
- miss: rsp_valid 1 cycle after the fill_done cycle.
REQ-027 LRU order SHALL be a 4-entry permutation of buffer numbers.
REQ-028 Marking MRU SHALL move the touched buffer to the newest position and shift the buffers that were newer than it one step older; the relative order of all other buffers is preserved.
REQ-029 At most one request SHALL be outstanding; no tag aliasing check beyond the compare in REQ-019 is required.

Reset
REQ-030 On reset, the block SHALL enter IDLE and drive req_ready=1, rsp_valid=0, fill_req=0, rsp_hit=0, rsp_buf=0, fill_buf=0, fill_tag=0.
REQ-031 On reset, all valid bits and tags SHALL be 0, and the LRU order SHALL be 0 (oldest), 1, 2, 3 (newest).
REQ-032 Reset asserted mid-FILL or mid-RESP SHALL abandon the transaction; a later fill_done SHALL be ignored.

Configuration
REQ-033 With macro BUF_TAG_MGR_STATS_EN defined, the block SHALL add outputs hit_cnt[15:0] and miss_cnt[15:0].
- Each counter increments by one per response accepted in RESP, selected by rsp_hit.
- Both counters saturate at 16'hFFFF.
- Both counters reset to 0.
REQ-034 Without the macro, the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-035 A shared package SHALL hold:
- the state enum (IDLE, LOOKUP, FILL, RESP);
- constant NUM_BUF=4;
- the buffer-index typedef (2 bits);
- the LRU reset order constant.
REQ-036 The LRU order register and MRU-touch logic SHALL be a sub-module named lru_order4, with inputs touch_en and touch_buf[1:0], and output lru_buf[1:0] (the oldest buffer).

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Cold miss: after reset, req_tag=8'hA5 -> fill_req=1, fill_buf=0, fill_tag=8'hA5; fill_done -> rsp_valid, rsp_hit=0, rsp_buf=0.
- Hit: after filling tags 8'h10, 8'h11, 8'h12, 8'h13 into buffers 0-3, request 8'h12 -> rsp_hit=1, rsp_buf=2, rsp_valid 2 cycles after accept, no fill_req.
- LRU eviction: continue by requesting 8'h10, then 8'h77 -> fill_buf=1, the oldest buffer after the order becomes 1, 3, 2, 0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_hit and rsp_buf stable, req_ready=0 throughout; the response completes on the first cycle rsp_ready=1.
- Reset mid-FILL: assert rst_n=0 while fill_req=1, then pulse fill_done -> no state change, all valid bits 0, next request misses to buffer 0.
- Stats (BUF_TAG_MGR_STATS_EN defined): 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2; force the counters near saturation -> they hold at 16'hFFFF.
